lfsr_checker: RTL and testbench
===============================

Name: lfsr_checker

Overview:
- Receive-side checker for the Galois LFSR sequence generator; consumes the parallel state words that generator produces, one per valid beat.
- Self-synchronises onto the sequence, flywheels its own prediction once locked, and reports per-beat mismatches plus a saturating error count.
- Used on loopback and test paths to qualify links carrying LFSR pattern data.

Parameters:
- BITS, 8, width of the LFSR state word.
- TAPS, 8'hC3, tap mask; must equal the generator's TAPS.
- LOCK_COUNT, 4, consecutive correct predictions required to declare lock (>=1).
- LOSS_COUNT, 3, consecutive mismatches while locked that drop lock (>=1).
- CNT_BITS, 16, width of the error counter.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset.
- i_valid  in  1  i_data carries a new word this cycle.
- i_data  in  BITS  received LFSR state word.
- i_clear  in  1  synchronous clear of o_err_count.
- o_locked  out  1  checker locked to the sequence.
- o_error  out  1  one-cycle pulse: previous valid beat mismatched while locked.
- o_err_count  out  CNT_BITS  saturating count of locked-state mismatches.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- next(s) = s[0] ? (s>>1)^TAPS : (s>>1), BITS wide.
- Reset (async, active-low): state SEARCH, exp=0, have_prev=0, match_cnt=0, miss_cnt=0.
  - Outputs after reset: o_locked=0, o_error=0, o_err_count=0.
- All state and outputs are registered; a beat sampled on edge N is reflected on the outputs after edge N.
- i_valid=0: no state change; o_error=0 that cycle.
- SEARCH, on each valid beat:
  - Match: have_prev=1, i_data==exp and i_data!=0 -> match_cnt+1; otherwise match_cnt=0.
  - exp<=next(i_data); have_prev<=1.
  - A match that brings match_cnt to LOCK_COUNT -> go to LOCKED, o_locked<=1, match_cnt<=0, miss_cnt<=0.
  - No errors are counted and o_error stays 0 in SEARCH.
- LOCKED, on each valid beat (exp advances from its own value, not from i_data):
  - i_data==exp: miss_cnt<=0, exp<=next(exp).
  - Mismatch: o_error<=1 for one cycle, o_err_count+1 (saturates at all-ones), miss_cnt+1, exp<=next(exp).
  - A mismatch that brings miss_cnt to LOSS_COUNT -> go to SEARCH, o_locked<=0.
    - The error on this beat is still counted.
    - exp<=next(i_data), have_prev<=1, match_cnt<=0.
- All-zero i_data: never a match in SEARCH. In LOCKED it is an ordinary mismatch, since exp is never 0.
- i_clear: o_err_count<=0. Clear wins over a same-cycle increment. Lock state and o_error are unaffected.
- Reset asserted mid-operation: everything returns immediately to the reset values; re-lock requires LOCK_COUNT+1 fresh valid beats.
- Counter widths: match_cnt holds 0..LOCK_COUNT; miss_cnt holds 0..LOSS_COUNT.

Test Plan:
- Lock: BITS=8, TAPS=C3, valid beats C3,A2,51,EB,B6 -> o_locked rises after the B6 beat (not before); o_error stays 0; count=0.
- Single error: locked, continue with 5A (expected 5B) then EE,77 -> one o_error pulse after 5A; count=1; o_locked stays 1; EE and 77 match.
- Loss of lock: locked with exp=5B, send 00,00,00 -> three o_error pulses, count=3; o_locked falls after the third beat. Then send next(00)=00 repeatedly -> never relocks.
- Gaps and clear: lock sequence with i_valid=0 bubbles between beats -> identical lock timing in beats. Assert i_clear on the same cycle as a mismatch beat -> count reads 0 and o_error still pulses.
- Saturation: CNT_BITS=2, locked, LOSS_COUNT=8, alternate wrong and correct words for 5 mismatches -> count sticks at 3 and o_locked stays 1.
- Reset mid-run: locked with count=2, pulse i_rst_n low asynchronously between edges -> o_locked, o_error and count are 0 immediately; relock needs 5 correct beats.

Source files
------------

// File: rtl/lfsr_checker.sv
// Receive-side checker for a Galois LFSR word stream: self-synchronises, flywheels
// its own prediction once locked, and counts mismatches seen while locked.
//
//  state  | meaning
//  SEARCH | seeding exp from received words; waiting for LOCK_COUNT consecutive correct predictions
//  LOCKED | exp advances on its own; mismatches are flagged and counted, LOSS_COUNT in a row drop lock
module lfsr_checker #(
    parameter int              BITS       = 8,
    parameter logic [BITS-1:0] TAPS       = 8'hC3,
    parameter int              LOCK_COUNT = 4,
    parameter int              LOSS_COUNT = 3,
    parameter int              CNT_BITS   = 16
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_valid,
    input  logic [BITS-1:0]     i_data,
    input  logic                i_clear,
    output logic                o_locked,
    output logic                o_error,
    output logic [CNT_BITS-1:0] o_err_count
);

    localparam int MW  = (LOCK_COUNT < 1) ? 1 : $clog2(LOCK_COUNT + 1);
    localparam int MSW = (LOSS_COUNT < 1) ? 1 : $clog2(LOSS_COUNT + 1);
    localparam logic [MW-1:0]  MATCH_LAST = MW'(LOCK_COUNT - 1);
    localparam logic [MSW-1:0] MISS_LAST  = MSW'(LOSS_COUNT - 1);

    typedef enum logic {SEARCH, LOCKED} state_t;

    state_t              state_q, state_d;
    logic [BITS-1:0]     exp_q, exp_d;
    logic                have_prev_q, have_prev_d;
    logic [MW-1:0]       match_q, match_d;
    logic [MSW-1:0]      miss_q, miss_d;
    logic                error_q, error_d;
    logic [CNT_BITS-1:0] count_q, count_d;

    function automatic logic [BITS-1:0] lfsr_next(input logic [BITS-1:0] s);
        return s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
    endfunction

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= SEARCH;
            exp_q       <= '0;
            have_prev_q <= 1'b0;
            match_q     <= '0;
            miss_q      <= '0;
            error_q     <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            exp_q       <= exp_d;
            have_prev_q <= have_prev_d;
            match_q     <= match_d;
            miss_q      <= miss_d;
            error_q     <= error_d;
            count_q     <= count_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        exp_d       = exp_q;
        have_prev_d = have_prev_q;
        match_d     = match_q;
        miss_d      = miss_q;
        error_d     = 1'b0;
        count_d     = count_q;

        if (i_valid) begin
            case (state_q)
                SEARCH: begin
                    exp_d       = lfsr_next(i_data);
                    have_prev_d = 1'b1;
                    // all-zero is the LFSR lock-up word, so it never counts toward lock
                    if (have_prev_q && (i_data == exp_q) && (i_data != '0)) begin
                        if (match_q == MATCH_LAST) begin
                            state_d = LOCKED;
                            match_d = '0;
                            miss_d  = '0;
                        end else begin
                            match_d = match_q + 1'b1;
                        end
                    end else begin
                        match_d = '0;
                    end
                end
                LOCKED: begin
                    exp_d = lfsr_next(exp_q);
                    if (i_data == exp_q) begin
                        miss_d = '0;
                    end else begin
                        error_d = 1'b1;
                        if (count_q != '1) count_d = count_q + 1'b1;
                        if (miss_q == MISS_LAST) begin
                            // reseed from the offending word so resync starts immediately
                            state_d     = SEARCH;
                            exp_d       = lfsr_next(i_data);
                            have_prev_d = 1'b1;
                            match_d     = '0;
                            miss_d      = '0;
                        end else begin
                            miss_d = miss_q + 1'b1;
                        end
                    end
                end
                default: state_d = SEARCH;
            endcase
        end

        if (i_clear) count_d = '0;
    end

    assign o_locked    = (state_q == LOCKED);
    assign o_error     = error_q;
    assign o_err_count = count_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker: default instance plus a narrow-counter instance
// (CNT_BITS=2, LOSS_COUNT=8) sharing the same stimulus.
module tb_lfsr_checker;

    logic        clk;
    logic        rst_n;
    logic        valid;
    logic [7:0]  data;
    logic        clear;
    logic        locked, error;
    logic [15:0] err_count;
    logic        s_locked, s_error;
    logic [1:0]  s_err_count;

    int n_checks = 0;
    int n_fail   = 0;

    lfsr_checker dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_data(data), .i_clear(clear),
        .o_locked(locked), .o_error(error), .o_err_count(err_count)
    );

    lfsr_checker #(.CNT_BITS(2), .LOSS_COUNT(8)) dut_sat (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_data(data), .i_clear(clear),
        .o_locked(s_locked), .o_error(s_error), .o_err_count(s_err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic beat(input logic [7:0] d, input logic clr = 1'b0);
        valid = 1'b1;
        data  = d;
        clear = clr;
        @(posedge clk);
        #1;
        valid = 1'b0;
        clear = 1'b0;
    endtask

    task automatic bubble();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        valid = 1'b0;
        data  = 8'h00;
        clear = 1'b0;
        #23 rst_n = 1'b1;
        @(posedge clk);
        #1;

        check("rst_locked", {31'd0, locked}, 32'd0);
        check("rst_error", {31'd0, error}, 32'd0);
        check("rst_count", {16'd0, err_count}, 32'd0);

        // lock: C3 A2 51 EB B6, lock only after the fifth beat
        beat(8'hC3); check("lock_c3", {31'd0, locked}, 32'd0);
        beat(8'hA2); check("lock_a2", {31'd0, locked}, 32'd0);
        beat(8'h51); check("lock_51", {31'd0, locked}, 32'd0);
        beat(8'hEB); check("lock_eb", {31'd0, locked}, 32'd0);
        beat(8'hB6);
        check("lock_b6", {31'd0, locked}, 32'd1);
        check("lock_err", {31'd0, error}, 32'd0);
        check("lock_cnt", {16'd0, err_count}, 32'd0);
        check("sat_lock", {31'd0, s_locked}, 32'd1);

        // single error: 5A where 5B expected, then EE 77 match
        beat(8'h5A);
        check("err1_pulse", {31'd0, error}, 32'd1);
        check("err1_cnt", {16'd0, err_count}, 32'd1);
        check("err1_locked", {31'd0, locked}, 32'd1);
        bubble();
        check("idle_err", {31'd0, error}, 32'd0);
        beat(8'hEE); check("ee_err", {31'd0, error}, 32'd0);
        beat(8'h77); check("77_err", {31'd0, error}, 32'd0);
        check("77_cnt", {16'd0, err_count}, 32'd1);

        // saturation: alternate wrong/correct, exp F8 7C 3E 1F CC 66 33 DA 6D
        beat(8'h00); check("sat_c2", {30'd0, s_err_count}, 32'd2);
        beat(8'h7C); check("sat_ok1", {31'd0, s_error}, 32'd0);
        beat(8'h00); check("sat_c3", {30'd0, s_err_count}, 32'd3);
        beat(8'h1F);
        beat(8'h00); check("sat_c4", {30'd0, s_err_count}, 32'd3);
        beat(8'h66);
        beat(8'h00);
        beat(8'hDA);
        beat(8'h00);
        check("sat_hold", {30'd0, s_err_count}, 32'd3);
        check("sat_locked", {31'd0, s_locked}, 32'd1);
        check("sat_err", {31'd0, s_error}, 32'd1);
        check("main_cnt6", {16'd0, err_count}, 32'd6);
        check("main_locked", {31'd0, locked}, 32'd1);

        // loss of lock: F5 correct, then three zeros
        beat(8'hF5); check("f5_err", {31'd0, error}, 32'd0);
        beat(8'h00); check("loss1", {31'd0, locked}, 32'd1);
        beat(8'h00); check("loss2", {31'd0, locked}, 32'd1);
        beat(8'h00);
        check("loss3_locked", {31'd0, locked}, 32'd0);
        check("loss3_err", {31'd0, error}, 32'd1);
        check("loss3_cnt", {16'd0, err_count}, 32'd9);
        for (int i = 0; i < 6; i++) beat(8'h00);
        check("zero_nolock", {31'd0, locked}, 32'd0);
        check("zero_noerr", {31'd0, error}, 32'd0);
        check("zero_cnt", {16'd0, err_count}, 32'd9);

        // gaps: same beat-count lock timing with bubbles between beats
        beat(8'hC3); bubble();
        beat(8'hA2); bubble(); bubble();
        beat(8'h51); bubble();
        beat(8'hEB); bubble();
        check("gap_eb", {31'd0, locked}, 32'd0);
        beat(8'hB6);
        check("gap_b6", {31'd0, locked}, 32'd1);

        // clear on a mismatch beat: count clears, error still pulses
        beat(8'h5A, 1'b1);
        check("clr_cnt", {16'd0, err_count}, 32'd0);
        check("clr_err", {31'd0, error}, 32'd1);
        check("clr_locked", {31'd0, locked}, 32'd1);

        beat(8'h00);
        beat(8'h77);
        beat(8'h00);
        check("pre_rst_cnt", {16'd0, err_count}, 32'd2);

        // async reset between edges
        #2 rst_n = 1'b0;
        #1;
        check("arst_locked", {31'd0, locked}, 32'd0);
        check("arst_err", {31'd0, error}, 32'd0);
        check("arst_cnt", {16'd0, err_count}, 32'd0);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        beat(8'hC3);
        beat(8'hA2);
        beat(8'h51);
        beat(8'hEB); check("relock_eb", {31'd0, locked}, 32'd0);
        beat(8'hB6); check("relock_b6", {31'd0, locked}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
